// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Parametrised modulo up/down counter with programmable modulus (0..MAX_VAL),
// variable step, direction control, parallel load and three limit modes
// (wrap, saturate, one-shot). Reports terminal-count pulses and a sticky
// overflow flag.
//
// Ports
//   clk_i          system clock, all state updates on the rising edge
//   reset_i        synchronous active-high reset
//   enable_i       advance the count by step_i this cycle
//   dir_i          1 = count up, 0 = count down
//   mode_i         00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   step_i         increment magnitude (0 holds the count)
//   load_i         parallel load of load_val_i (beats enable_i)
//   load_val_i     value to load, clamped to MAX_VAL
//   clear_flags_i  clear the sticky overflow flag
//   count_o        current count (registered)
//   tc_o           terminal-count pulse, one cycle per crossing (registered)
//   at_limit_o     count at the limit in the current direction (combinational)
//   overflow_o     sticky limit-crossing / clamped-load flag (registered)
//   running_o      low only while halted in one-shot mode (registered)
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clear_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             at_limit_o,
  output logic             overflow_o,
  output logic             running_o
);

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SATURATE = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  // Limit and modulus carried one bit wider so MAX_VAL+1 is representable.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             overflow_q, overflow_d;
  logic             halted_q, halted_d;

  logic [WIDTH:0]   count_ext_s;
  logic [WIDTH:0]   step_ext_s;
  logic [WIDTH:0]   load_ext_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   next_ext_s;
  logic             cross_s;
  logic             set_ovf_s;

  assign count_ext_s = {1'b0, count_q};
  assign step_ext_s  = {1'b0, step_i};
  assign load_ext_s  = {1'b0, load_val_i};
  assign sum_s       = count_ext_s + step_ext_s;

  // Crossing detect in WIDTH+1 bits; step 0 can never cross in either direction.
  assign cross_s = dir_i ? (sum_s > MAX_EXT) : (step_ext_s > count_ext_s);

  // Next-state computation: load has priority over enable; halted ignores enable.
  always_comb begin
    count_d    = count_q;
    tc_d       = 1'b0;
    halted_d   = halted_q;
    set_ovf_s  = 1'b0;
    next_ext_s = count_ext_s;

    if (load_i) begin
      halted_d = 1'b0;
      if (load_ext_s > MAX_EXT) begin
        count_d   = MAX_W;
        set_ovf_s = 1'b1;
      end else begin
        count_d = load_val_i;
      end
    end else if (enable_i && !halted_q) begin
      if (cross_s) begin
        tc_d      = 1'b1;
        set_ovf_s = 1'b1;
        case (mode_i)
          MODE_SATURATE: begin
            next_ext_s = dir_i ? MAX_EXT : {(WIDTH+1){1'b0}};
          end
          MODE_ONESHOT: begin
            next_ext_s = dir_i ? MAX_EXT : {(WIDTH+1){1'b0}};
            halted_d   = 1'b1;
          end
          MODE_WRAP: begin
            next_ext_s = dir_i ? (sum_s - MOD_EXT) : (count_ext_s + MOD_EXT - step_ext_s);
          end
          default: begin
            // Mode 11 behaves as wrap.
            next_ext_s = dir_i ? (sum_s - MOD_EXT) : (count_ext_s + MOD_EXT - step_ext_s);
          end
        endcase
      end else begin
        next_ext_s = dir_i ? sum_s : (count_ext_s - step_ext_s);
      end
      count_d = next_ext_s[WIDTH-1:0];
    end else begin
      count_d = count_q;
    end

    // Setting the flag wins over a simultaneous clear.
    if (set_ovf_s) begin
      overflow_d = 1'b1;
    end else if (clear_flags_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= {WIDTH{1'b0}};
      tc_q       <= 1'b0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      count_q    <= count_d;
      tc_q       <= tc_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
    end
  end

  assign count_o    = count_q;
  assign tc_o       = tc_q;
  assign overflow_o = overflow_q;
  assign running_o  = ~halted_q;
  assign at_limit_o = dir_i ? (count_q == MAX_W) : (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned MX = 9;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         dir;
  logic [1:0]   mode;
  logic [W-1:0] step;
  logic         load;
  logic [W-1:0] load_val;
  logic         clear_flags;
  logic [W-1:0] count;
  logic         tc;
  logic         at_limit;
  logic         overflow;
  logic         running;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         ovf;
    logic         run;
    logic         al;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  mod_counter #(.WIDTH(W), .MAX_VAL(MX)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .dir_i         (dir),
    .mode_i        (mode),
    .step_i        (step),
    .load_i        (load),
    .load_val_i    (load_val),
    .clear_flags_i (clear_flags),
    .count_o       (count),
    .tc_o          (tc),
    .at_limit_o    (at_limit),
    .overflow_o    (overflow),
    .running_o     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
  task automatic drive(input logic rst, input logic en, input logic d, input logic [1:0] md,
                       input logic [W-1:0] st, input logic ld, input logic [W-1:0] lv,
                       input logic clr, input logic [W-1:0] ecnt, input logic etc,
                       input logic eovf, input logic erun, input logic eal, input string nm);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    enable      = en;
    dir         = d;
    mode        = md;
    step        = st;
    load        = ld;
    load_val    = lv;
    clear_flags = clr;
    e.cnt = ecnt; e.tc = etc; e.ovf = eovf; e.run = erun; e.al = eal;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  // Monitor: after each rising edge pop one expectation and compare the outputs.
  always begin
    exp_t  e;
    exp_t  a;
    string nm;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.cnt = count; a.tc = tc; a.ovf = overflow; a.run = running; a.al = at_limit;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b run=%0b al=%0b, expected cnt=%0d tc=%0b ovf=%0b run=%0b al=%0b",
                 nm, a.cnt, a.tc, a.ovf, a.run, a.al, e.cnt, e.tc, e.ovf, e.run, e.al);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; enable = 1'b0; dir = 1'b1; mode = 2'b00; step = 4'd0;
    load = 1'b0; load_val = 4'd0; clear_flags = 1'b0;

    //     rst   en    dir   mode   step  ld    lv     clr   cnt   tc    ovf   run   al
    drive(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");

    // Wrap up by one: 1..9 then 0 with tc only on the wrap.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'b00, 4'd1, 1'b0, 4'd0, 1'b0,
            4'(i % 10), 1'(i == 10), 1'(i == 10), 1'b1, 1'(i == 9), "wrap_up");
    end

    // Wrap down by three starting from 2.
    drive(1'b0, 1'b0, 1'b0, 2'b00, 4'd3, 1'b1, 4'd2,  1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, "down_load2");
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0, "down_wrap9");
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 1'b0, 4'd0,  1'b0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, "down_6");
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 1'b0, 4'd0,  1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, "down_3");
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, "down_0_exact");

    // Saturate up by four from 7, clear colliding with a crossing.
    drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd4, 1'b0, 4'd0,  1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "clear_ovf");
    drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd4, 1'b1, 4'd7,  1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, "sat_load7");
    drive(1'b0, 1'b1, 1'b1, 2'b01, 4'd4, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, "sat_1");
    drive(1'b0, 1'b1, 1'b1, 2'b01, 4'd4, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, "sat_2");
    drive(1'b0, 1'b1, 1'b1, 2'b01, 4'd4, 1'b0, 4'd0,  1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, "sat_3_set_wins");
    drive(1'b0, 1'b0, 1'b1, 2'b01, 4'd4, 1'b0, 4'd0,  1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, "sat_clear");

    // One-shot up by five from 0.
    drive(1'b0, 1'b0, 1'b1, 2'b10, 4'd5, 1'b1, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "os_load0");
    drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd5, 1'b0, 4'd0,  1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, "os_5");
    drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd5, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, "os_halt");
    drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd5, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, "os_held1");
    drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd5, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, "os_held2");
    drive(1'b0, 1'b0, 1'b1, 2'b10, 4'd5, 1'b1, 4'd3,  1'b0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, "os_reload3");

    // Clamped load, load beats enable, set beats clear on load.
    drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 1'b0, 4'd0,  1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, "clear2");
    drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, "load_clamp");
    drive(1'b0, 1'b1, 1'b1, 2'b00, 4'd1, 1'b1, 4'd4,  1'b0, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, "load_wins");
    drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 1'b0, 4'd0,  1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, "clear3");
    drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 1'b1, 4'd12, 1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b1, "clamp_vs_clear");

    // Halt at 9 with overflow, then reset (with enable high) and step 0 hold.
    drive(1'b0, 1'b1, 1'b1, 2'b10, 4'd1, 1'b0, 4'd0,  1'b0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, "os_halt9");
    drive(1'b1, 1'b1, 1'b1, 2'b10, 4'd1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_halted");
    drive(1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, "step0_up");
    drive(1'b0, 1'b1, 1'b0, 2'b01, 4'd0, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, "step0_down");

    // Full-modulus step (MAX_VAL+1) wraps back to the same value in both directions.
    drive(1'b0, 1'b1, 1'b0, 2'b11, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, "step10_down");
    drive(1'b0, 1'b0, 1'b1, 2'b11, 4'd10, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, "load5");
    drive(1'b0, 1'b1, 1'b1, 2'b11, 4'd10, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, "step10_up");
    // Saturate down at zero: every enabled step is a crossing.
    drive(1'b0, 1'b0, 1'b0, 2'b01, 4'd2, 1'b1, 4'd1,  1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, "load1_clr");
    drive(1'b0, 1'b1, 1'b0, 2'b01, 4'd2, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, "satdn_1");
    drive(1'b0, 1'b1, 1'b0, 2'b01, 4'd2, 1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, "satdn_2");
    drive(1'b0, 1'b0, 1'b0, 2'b01, 4'd2, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, "idle");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter that supersedes the fixed 8-bit free-running counter. It adds a programmable modulus, variable step, direction control, parallel load, and three limit modes: wrap, saturate and one-shot. It also reports terminal-count events and a sticky overflow flag. It is the standard counting primitive for sequencers and timers in the datapath, on the single system clock.

## Interface
- WIDTH, 8: counter width in bits.
- MAX_VAL, 2**WIDTH-1: upper count limit, inclusive. Legal range 1..2**WIDTH-1. The count range is 0..MAX_VAL.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance the count by step this cycle.
- dir  in  1  1 = count up, 0 = count down.
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- step  in  WIDTH  increment magnitude. Must be <= MAX_VAL+1. A value of 0 holds the count.
- load  in  1  parallel load of load_val.
- load_val  in  WIDTH  value to load.
- clear_flags  in  1  clear overflow.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered, one cycle per event).
- at_limit  out  1  combinational: count==MAX_VAL when dir=1; count==0 when dir=0.
- overflow  out  1  sticky limit-crossing flag (registered).
- running  out  1  0 only while halted in one-shot mode.

## Operation
- Reset values: count=0, tc=0, overflow=0, running=1 (halted cleared).
- Priority per cycle: reset > load > enable.
- Load:
  - count <= min(load_val, MAX_VAL); halted cleared.
  - If load_val > MAX_VAL: overflow <= 1. No tc on load.
- Enable with halted=1: ignored, count held, tc=0.
- Arithmetic: computed in WIDTH+1 bits, no truncation before the limit check.
  - Up: sum = count + step. It crosses when sum > MAX_VAL.
  - Down: it crosses when step > count.
- Non-crossing step: count <= count ± step. Landing exactly on a limit is not a crossing (no tc; at_limit goes high).
- Crossing step, by mode:
  - Wrap, up: count <= sum - (MAX_VAL+1).
  - Wrap, down: count <= count + (MAX_VAL+1) - step.
  - Saturate: count <= MAX_VAL (up) or 0 (down).
  - One-shot: count <= MAX_VAL (up) or 0 (down), and halted <= 1.
  - Every crossing in every mode: tc=1 for that cycle and overflow <= 1.
- Saturate mode held at a limit with enable and step>0 toward that limit: each cycle is a crossing, so tc pulses every cycle.
- step=0 with enable: count held, no tc, in all modes.
- clear_flags clears overflow. If a crossing or clamped load occurs in the same cycle, set wins and overflow stays 1.
- mode, dir and step are sampled each cycle. Changing them mid-count takes effect on the next enabled edge, with no other side effect.
- Reset mid-operation (any mode, halted or not): all state returns to reset values at that edge.

## Timing
- count, tc, overflow and running change only on the rising edge of clk. at_limit follows count and dir combinationally.
- Latency: the effect of enable, load or reset is visible at count in the cycle after the sampling edge (one-cycle latency).
- tc is asserted in exactly the cycle in which count shows the post-crossing value, and deasserts on the next edge unless another crossing occurs.
- running falls in the same cycle tc is asserted for a one-shot crossing. It rises in the cycle after a load or reset edge.

## Test plan
- WIDTH=4, MAX_VAL=9, wrap, dir=1, step=1, enable held from count 0 -> count 1..9 then 0. tc=1 only in the cycle count=0; overflow=1 afterwards; at_limit=1 while count=9.
- Same configuration, down, step=3, start by loading 2 -> next count=9 (2+10-3) with tc=1, then 6, 3, 0. At 0, at_limit=1 and tc=0.
- Saturate, up, step=4, load 7, enable 3 cycles -> count 9, 9, 9 with tc=1 on each of the 3 cycles. Pulse clear_flags together with the 3rd enable -> overflow stays 1. Next cycle, clear_flags alone -> overflow=0.
- One-shot, up, step=5, from 0 -> count 5, then 9 with tc=1 and running=0. Further enables: count stays 9, tc=0. load=1, load_val=3 -> count=3, running=1.
- load_val=15 with MAX_VAL=9 -> count=9, overflow=1, tc=0. load and enable in the same cycle -> load wins.
- Assert reset for one cycle while halted with overflow=1 and count=9 -> next cycle count=0, tc=0, overflow=0, running=1. enable with step=0 -> count holds at 0.
